// File: rtl/ysyx_22051013_pipe_ctrl.sv
// ysyx_22051013_pipe_ctrl: hazard/stall scheduler for the 5-stage IF/ID/EX/LS/WB pipeline
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   id_rs1_ena/addr, id_rs2_ena/addr  source operands of the ID instruction
//   ex_is_load, ex_rd_ena, ex_rd_addr destination of the EX instruction
//   ex_redirect                       EX resolved a taken branch/jump
//   ls_mem_req/ready, if_mem_req/ready data and fetch memory handshakes
//   *_stall, *_flush                  per-stage hold / bubble strobes (combinational)
//   ctrl_state                        0 RUN, 1 LS_WAIT, 2 IF_WAIT (status only)
//   stall_cycles, flush_count         saturating performance counters
//   mem_timeout                       sticky: data-memory wait reached TIMEOUT cycles
module ysyx_22051013_pipe_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_rs1_ena,
    input  logic [4:0]       id_rs1_addr,
    input  logic             id_rs2_ena,
    input  logic [4:0]       id_rs2_addr,
    input  logic             ex_is_load,
    input  logic             ex_rd_ena,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_redirect,
    input  logic             ls_mem_req,
    input  logic             ls_mem_ready,
    input  logic             if_mem_req,
    input  logic             if_mem_ready,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_stall,
    output logic             exls_stall,
    output logic             lswb_flush,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);
    localparam int WC_W = $clog2(TIMEOUT) + 1;
    typedef enum logic [1:0] {RUN = 2'd0, LS_WAIT = 2'd1, IF_WAIT = 2'd2} state_t;
    state_t          r_state, w_next;
    logic [WC_W-1:0] r_wait_cnt;
    logic            w_ls_hold, w_if_hold, w_load_use, w_redir_act, w_wc_top;
    assign w_ls_hold  = ls_mem_req & ~ls_mem_ready;
    assign w_if_hold  = if_mem_req & ~if_mem_ready;
    assign w_load_use = ex_is_load & ex_rd_ena & (ex_rd_addr != 5'd0) &
                        ((id_rs1_ena & (id_rs1_addr == ex_rd_addr)) |
                         (id_rs2_ena & (id_rs2_addr == ex_rd_addr)));
    // A redirect is dropped while LS is frozen and masked by a load-use bubble;
    // during a fetch wait it is still taken because IF re-fetches anyway.
    assign w_redir_act = ~w_ls_hold & ex_redirect & (w_if_hold | ~w_load_use);
    // wait_cnt parks at TIMEOUT-1 so a very long wait cannot wrap it.
    assign w_wc_top    = r_wait_cnt == WC_W'(TIMEOUT - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= RUN;
            r_wait_cnt   <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            r_state      <= w_next;
            r_wait_cnt   <= !w_ls_hold ? '0 : w_wc_top ? r_wait_cnt : r_wait_cnt + 1'b1;
            mem_timeout  <= mem_timeout | (w_ls_hold & w_wc_top);
            stall_cycles <= stall_cycles + CNT_W'(pc_stall & ~&stall_cycles);
            flush_count  <= flush_count + CNT_W'(w_redir_act & ~&flush_count);
        end
    end
    always_comb begin
        w_next = w_ls_hold ? LS_WAIT : (r_state == LS_WAIT) ? RUN : w_if_hold ? IF_WAIT : RUN;
    end
    always_comb begin
        pc_stall   = w_ls_hold | w_if_hold | w_load_use;
        ifid_stall = w_ls_hold | (~w_if_hold & w_load_use);
        idex_stall = w_ls_hold;
        exls_stall = w_ls_hold;
        lswb_flush = w_ls_hold;
        ifid_flush = ~w_ls_hold & (w_if_hold | (~w_load_use & ex_redirect));
        idex_flush = ~w_ls_hold & (w_if_hold ? ex_redirect : (w_load_use | ex_redirect));
        ctrl_state = r_state;
    end
endmodule

// File: tb/tb_ysyx_22051013_pipe_ctrl.sv
// tb_ysyx_22051013_pipe_ctrl: directed and random checks of the pipeline hazard scheduler
module tb_ysyx_22051013_pipe_ctrl;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;
    logic clk = 1'b0, rst = 1'b1;
    logic id_rs1_ena, id_rs2_ena, ex_is_load, ex_rd_ena, ex_redirect;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic ls_mem_req, ls_mem_ready, if_mem_req, if_mem_ready;
    logic pc_stall, ifid_stall, idex_stall, exls_stall, lswb_flush, ifid_flush, idex_flush;
    logic [1:0] ctrl_state;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic mem_timeout;
    int checks = 0, errors = 0;
    int m_state, m_stall, m_flush, m_wait, m_to;

    ysyx_22051013_pipe_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_ena(id_rs1_ena), .id_rs1_addr(id_rs1_addr),
        .id_rs2_ena(id_rs2_ena), .id_rs2_addr(id_rs2_addr),
        .ex_is_load(ex_is_load), .ex_rd_ena(ex_rd_ena), .ex_rd_addr(ex_rd_addr),
        .ex_redirect(ex_redirect),
        .ls_mem_req(ls_mem_req), .ls_mem_ready(ls_mem_ready),
        .if_mem_req(if_mem_req), .if_mem_ready(if_mem_ready),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
        .exls_stall(exls_stall), .lswb_flush(lswb_flush), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .ctrl_state(ctrl_state),
        .stall_cycles(stall_cycles), .flush_count(flush_count), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r1e, input logic [4:0] r1a, input logic r2e,
                         input logic [4:0] r2a, input logic ld, input logic rde,
                         input logic [4:0] rda, input logic redir, input logic lq,
                         input logic lr, input logic iq, input logic ir);
        id_rs1_ena = r1e; id_rs1_addr = r1a; id_rs2_ena = r2e; id_rs2_addr = r2a;
        ex_is_load = ld; ex_rd_ena = rde; ex_rd_addr = rda; ex_redirect = redir;
        ls_mem_req = lq; ls_mem_ready = lr; if_mem_req = iq; if_mem_ready = ir;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_reset();
        m_state = 0; m_stall = 0; m_flush = 0; m_wait = 0; m_to = 0;
    endtask

    // Checks the current cycle against the rule-based model, then advances one clock.
    task automatic step(input string tag);
        bit lh, ih, lu, acted;
        logic [6:0] e;
        #1;
        lh = ls_mem_req && !ls_mem_ready;
        ih = if_mem_req && !if_mem_ready;
        lu = ex_is_load && ex_rd_ena && ex_rd_addr != 0 &&
             ((id_rs1_ena && id_rs1_addr == ex_rd_addr) || (id_rs2_ena && id_rs2_addr == ex_rd_addr));
        // {pc_stall, ifid_stall, idex_stall, exls_stall, lswb_flush, ifid_flush, idex_flush}
        if (lh)               e = 7'b1111100;
        else if (ih)          e = {6'b100001, ex_redirect};
        else if (lu)          e = 7'b1100001;
        else if (ex_redirect) e = 7'b0000011;
        else                  e = 7'b0000000;
        acted = !lh && ex_redirect && (ih || !lu);
        chk({tag, ".strobes"}, 32'({pc_stall, ifid_stall, idex_stall, exls_stall,
                                    lswb_flush, ifid_flush, idex_flush}), 32'(e));
        chk({tag, ".state"}, 32'(ctrl_state), 32'(m_state));
        chk({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(m_stall));
        chk({tag, ".flush_count"}, 32'(flush_count), 32'(m_flush));
        chk({tag, ".mem_timeout"}, 32'(mem_timeout), 32'(m_to));
        @(posedge clk);
        case (m_state)
            0:       m_state = lh ? 1 : ih ? 2 : 0;
            1:       m_state = lh ? 1 : 0;
            default: m_state = lh ? 1 : ih ? 2 : 0;
        endcase
        if (e[6]) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
        if (acted) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
        m_wait = lh ? m_wait + 1 : 0;
        if (m_wait >= TIMEOUT) m_to = 1;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        idle();
        model_reset();
        #1;
        chk("reset.state", 32'(ctrl_state), 0);
        chk("reset.counters", 32'({stall_cycles, flush_count, mem_timeout}), 0);
        chk("reset.strobes", 32'({pc_stall, ifid_stall, idex_stall, exls_stall,
                                  lswb_flush, ifid_flush, idex_flush}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("idle");
        // Load-use: EX ld x5, ID add x6,x5,x1
        drive(1, 5, 1, 1, 1, 1, 5, 0, 0, 0, 0, 0);
        step("lu");
        idle();
        step("lu_after");
        chk("lu.stall_cycles", 32'(stall_cycles), 1);
        drive(1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        step("lu_x0");
        drive(0, 5, 1, 5, 1, 1, 5, 0, 0, 0, 0, 0);
        step("lu_rs2");
        // LS wait three cycles, then ready
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
            step("ls_wait");
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        step("ls_ready");
        idle();
        step("ls_run");
        chk("ls.stall_cycles", 32'(stall_cycles), 3);
        // Redirect held behind an LS wait
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
            step("redir_ls");
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        step("redir_release");
        idle();
        step("redir_after");
        chk("redir.flush_count", 32'(flush_count), 1);
        // Fetch wait plus redirect in the same cycle
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        step("if_redir");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("if_wait");
        chk("if.state", 32'(ctrl_state), 2);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        step("if_to_ls");
        idle();
        step("if_done");
        // Timeout after TIMEOUT held cycles, then reset mid-wait
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
            step("timeout");
        end
        chk("timeout.sticky", 32'(mem_timeout), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.state", 32'(ctrl_state), 0);
        chk("midrst.regs", 32'({stall_cycles, flush_count, mem_timeout}), 0);
        idle();
        #1;
        chk("midrst.strobes", 32'({pc_stall, ifid_stall, idex_stall, exls_stall,
                                   lswb_flush, ifid_flush, idex_flush}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        // Counter saturation
        for (int i = 0; i < 20; i++) begin
            drive(1, 3, 0, 0, 1, 1, 3, 0, 0, 0, 0, 0);
            step("sat");
        end
        chk("sat.stall_cycles", 32'(stall_cycles), CMAX);
        // Random traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
            step("rand");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
